// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction fetch and a load/store requester.
// Conflicts alternate priority; each access ends with a one-cycle ok pulse.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ok,

  output logic        stall,
  output logic        err_timeout
);

  localparam int CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} stateT;
  typedef enum logic {GrantInst, GrantData} grantT;

  stateT           state;
  grantT           lastGrant;
  logic [CntW-1:0] waitCnt;
  logic            pickData;

  // Data wins a conflict unless it was the most recent grant.
  assign pickData = data_req && (!inst_req || lastGrant == GrantInst);

  assign stall = (inst_req & ~inst_ok) | (data_req & ~data_ok);

  // NOTE: every register here uses non-blocking assignment so all state sees
  // pre-edge values; blocking would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, since their values are
      // visible on the ports and must read zero while rst is high.
      state       <= IDLE;
      lastGrant   <= GrantInst;
      waitCnt     <= '0;
      mem_req     <= 1'b0;
      mem_wen     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      inst_ok     <= 1'b0;
      data_ok     <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
      err_timeout <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (pickData) begin
            state     <= DATA;
            lastGrant <= GrantData;
            waitCnt   <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= data_addr;
            mem_wen   <= data_wen;
            mem_wdata <= data_wdata;
          end else if (inst_req) begin
            state     <= INST;
            lastGrant <= GrantInst;
            waitCnt   <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= inst_addr;
            mem_wen   <= 4'b0000;
            mem_wdata <= '0;
          end
        end
        INST, DATA: begin
          if (mem_ok) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (state == INST) begin
              inst_rdata <= mem_rdata;
              inst_ok    <= 1'b1;
            end else begin
              data_ok <= 1'b1;
              if (mem_wen == 4'b0000) data_rdata <= mem_rdata;
            end
          end else if (waitCnt != TimeoutVal) begin
            // Timeout only flags; the access keeps waiting for mem_ok.
            waitCnt <= waitCnt + CntW'(1);
            if (waitCnt + CntW'(1) == TimeoutVal) err_timeout <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instReq, dataReq, memOk;
  logic [31:0] instAddr, dataAddr, dataWdata, memRdata;
  logic [3:0]  dataWen;
  logic        instOk, dataOk, memReq, stall, errTimeout;
  logic [31:0] instRdata, dataRdata, memAddr, memWdata;
  logic [3:0]  memWen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(instReq), .inst_addr(instAddr), .inst_ok(instOk), .inst_rdata(instRdata),
    .data_req(dataReq), .data_wen(dataWen), .data_addr(dataAddr), .data_wdata(dataWdata),
    .data_ok(dataOk), .data_rdata(dataRdata),
    .mem_req(memReq), .mem_wen(memWen), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_ok(memOk),
    .stall(stall), .err_timeout(errTimeout)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: who holds the memory port, whose ok is pulsing, and the
  // values the outputs must show.
  int          owner;       // 0 none, 1 fetch, 2 load/store
  int          doneFor;     // requester whose ok pulses this cycle
  bit          dataWonLast;
  int          waited;
  bit          expErr;
  logic [31:0] expAddr, expWdata, expInstRd, expDataRd;
  logic [3:0]  expWen;

  bit instPend, dataPend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    owner = 0; doneFor = 0; dataWonLast = 0; waited = 0; expErr = 0;
    expAddr = '0; expWdata = '0; expInstRd = '0; expDataRd = '0; expWen = '0;
  endtask

  // One rising edge of the arbitration rules, using the inputs present at the edge.
  task automatic modelEdge();
    if (doneFor != 0) begin
      doneFor = 0;                       // turnaround cycle: requests ignored
    end else if (owner != 0) begin
      if (memOk) begin
        if (owner == 1) expInstRd = memRdata;
        else if (expWen == 4'b0000) expDataRd = memRdata;
        doneFor = owner;
        owner = 0;
      end else begin
        if (waited < TIMEOUT) waited++;
        if (waited >= TIMEOUT) expErr = 1;
      end
    end else if (dataReq && (!instReq || !dataWonLast)) begin
      owner = 2; dataWonLast = 1; waited = 0;
      expAddr = dataAddr; expWen = dataWen; expWdata = dataWdata;
    end else if (instReq) begin
      owner = 1; dataWonLast = 0; waited = 0;
      expAddr = instAddr; expWen = 4'b0000; expWdata = '0;
    end
  endtask

  task automatic checkRegs();
    check("mem_req", memReq, owner != 0);
    check("mem_addr", memAddr, expAddr);
    check("mem_wen", memWen, expWen);
    check("mem_wdata", memWdata, expWdata);
    check("inst_ok", instOk, doneFor == 1);
    check("data_ok", dataOk, doneFor == 2);
    check("inst_rdata", instRdata, expInstRd);
    check("data_rdata", dataRdata, expDataRd);
    check("err_timeout", errTimeout, expErr);
  endtask

  // Inputs for the current cycle are already applied; check stall, clock once, check registers.
  task automatic step();
    #1;
    check("stall", stall, (instReq & ~(doneFor == 1)) | (dataReq & ~(doneFor == 2)));
    @(posedge clk);
    modelEdge();
    #1;
    cyc++;
    checkRegs();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #2;
    check("rst_mem_req", memReq, 0);
    check("rst_inst_ok", instOk, 0);
    check("rst_data_ok", dataOk, 0);
    check("rst_err", errTimeout, 0);
    check("rst_mem_wen", memWen, 0);
    check("rst_mem_addr", memAddr, 0);
    check("rst_mem_wdata", memWdata, 0);
    check("rst_inst_rdata", instRdata, 0);
    check("rst_data_rdata", dataRdata, 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc = 0;
  endtask

  task automatic randomInputs();
    if (doneFor == 1) begin
      instPend = 0;
      if ($urandom_range(0, 1) == 1) instReq = 1'b0;
    end else if (!instPend) begin
      if ($urandom_range(0, 99) < 40) begin
        instPend = 1; instReq = 1'b1; instAddr = $urandom & 32'hFFFF_FFFC;
      end else instReq = 1'b0;
    end else if (owner == 1 && $urandom_range(0, 99) < 5) instReq = 1'b0;

    if (doneFor == 2) begin
      dataPend = 0;
      if ($urandom_range(0, 1) == 1) dataReq = 1'b0;
    end else if (!dataPend) begin
      if ($urandom_range(0, 99) < 40) begin
        dataPend = 1; dataReq = 1'b1; dataAddr = $urandom;
        dataWen = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        dataWdata = $urandom;
      end else dataReq = 1'b0;
    end else if (owner == 2 && $urandom_range(0, 99) < 5) dataReq = 1'b0;

    memRdata = $urandom;
    memOk = (owner != 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 1) == 1);
  endtask

  logic [31:0] savedRd;
  int okCount, lastOkCyc;

  initial begin
    instReq = 0; dataReq = 0; memOk = 0; dataWen = 0;
    instAddr = 0; dataAddr = 0; dataWdata = 0; memRdata = 0;
    instPend = 0; dataPend = 0;

    // Single fetch: mem_ok in cycle 3, ok pulse in cycle 4.
    applyReset();
    instReq = 1; instAddr = 32'hBFC0_0000;
    step();
    check("fetch_memreq_c1", memReq, 1);
    step(); step();
    memOk = 1; memRdata = 32'h2402_0001;
    step();
    check("fetch_instok_c4", instOk, 1);
    check("fetch_rdata", instRdata, 32'h2402_0001);
    memOk = 0;
    step();
    instReq = 0;
    step();

    // Conflict from reset: data first, then alternation.
    instReq = 1; instAddr = 32'hBFC0_0100;
    dataReq = 1; dataWen = 4'b0000; dataAddr = 32'h8000_0010; dataWdata = 0;
    memOk = 1; memRdata = 32'h1111_2222;
    applyReset();
    step();
    check("conf_first_data", memAddr, 32'h8000_0010);
    step();
    check("conf_data_ok", dataOk, 1);
    check("conf_inst_wait", instOk, 0);
    dataAddr = 32'h8000_0020; memRdata = 32'h3333_4444;
    step(); step();
    check("conf_then_inst", memAddr, 32'hBFC0_0100);
    step();
    check("conf_inst_ok", instOk, 1);
    step(); step();
    check("conf_next_data", memAddr, 32'h8000_0020);
    step();
    check("conf_data_ok2", dataOk, 1);
    dataReq = 0;
    step(); step(); step();
    check("conf_inst_ok2", instOk, 1);
    instReq = 0; memOk = 0;
    step();

    // Store: byte enables and data forwarded, load data register untouched.
    savedRd = expDataRd;
    dataReq = 1; dataWen = 4'b0011; dataAddr = 32'h10; dataWdata = 32'hAABB_CCDD;
    memRdata = 32'hDEAD_BEEF;
    step();
    check("store_wen", memWen, 4'b0011);
    check("store_wdata", memWdata, 32'hAABB_CCDD);
    memOk = 1;
    step();
    check("store_ok", dataOk, 1);
    check("store_rdata_kept", dataRdata, savedRd);
    dataReq = 0; memOk = 0;
    step();

    // Back-to-back fetches with immediate mem_ok: one ok every third cycle.
    instReq = 1; memOk = 1; okCount = 0; lastOkCyc = -1;
    for (int i = 0; i < 15; i++) begin
      instAddr = 32'h1000 + 32'(i * 4);
      memRdata = $urandom;
      step();
      check("b2b_single_ok", instOk & dataOk, 0);
      if (instOk) begin
        if (lastOkCyc >= 0) check("b2b_gap", cyc - lastOkCyc, 3);
        lastOkCyc = cyc;
        okCount++;
      end
    end
    check("b2b_count", okCount, 5);
    instReq = 0;
    step(); step(); step();
    memOk = 0;

    // Timeout: mem_ok withheld for 10 cycles, flag from the 5th, access still completes.
    applyReset();
    instReq = 1; instAddr = 32'h0000_1000;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) check("timeout_not_yet", errTimeout, 0);
      if (i == 5) check("timeout_set", errTimeout, 1);
    end
    step();
    memOk = 1; memRdata = 32'h5A5A_0F0F;
    step();
    check("timeout_ok_still", instOk, 1);
    memOk = 0; instReq = 0;
    step(); step();
    check("timeout_sticky", errTimeout, 1);

    // Reset while a load is waiting: everything clears, no ok follows.
    dataReq = 1; dataWen = 4'b0000; dataAddr = 32'h2000;
    step(); step();
    check("midrst_busy", memReq, 1);
    dataReq = 0;
    applyReset();
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_ok", dataOk, 0);
    end

    // Randomized traffic.
    applyReset();
    instPend = 0; dataPend = 0;
    for (int i = 0; i < 3000; i++) begin
      randomInputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have this parameter: TIMEOUT, default 255, the number of cycles a granted access waits for mem_ok before err_timeout sets.
REQ-002 The block SHALL have the following ports.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held high with inst_addr stable until inst_ok.
- inst_addr  in  32  fetch address.
- inst_ok  out  1  one-cycle completion pulse for fetch.
- inst_rdata  out  32  fetch data; valid when inst_ok=1, held until the next fetch completes.
- data_req  in  1  load/store request; held high with addr/wen/wdata stable until data_ok.
- data_wen  in  4  byte enables; 0000 = load.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_ok  out  1  one-cycle completion pulse for load/store.
- data_rdata  out  32  load data; valid when data_ok=1 for a load.
- mem_req  out  1  request to the shared memory port, held until mem_ok.
- mem_wen  out  4  byte enables to memory.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  read data, valid with mem_ok.
- mem_ok  in  1  memory completion, sampled only while mem_req=1.
- stall  out  1  pipeline stall: (inst_req & ~inst_ok) | (data_req & ~data_ok), combinational.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, INST, DATA and RESP.
REQ-004 In IDLE with only data_req=1, the next state SHALL be DATA.
REQ-005 In IDLE with only inst_req=1, the next state SHALL be INST.
REQ-006 In IDLE with both requests high, the FSM SHALL grant INST if last_grant=DATA, else DATA (alternating priority).
REQ-007 The block SHALL update last_grant on every grant.
REQ-008 On each grant, mem_addr, mem_wen and mem_wdata SHALL be registered from the granted requester.
- For a fetch, mem_wen SHALL be 0000 and mem_wdata SHALL be 0.
REQ-009 In INST and DATA, mem_req SHALL be 1 and mem_addr/mem_wen/mem_wdata SHALL be held constant.
REQ-010 mem_req SHALL be 0 in IDLE and in RESP.
REQ-011 On mem_ok=1 in INST or DATA, the block SHALL capture mem_rdata into the granted requester's rdata register and enter RESP.
REQ-012 For a store, data_rdata SHALL keep its previous value.
REQ-013 In RESP, the block SHALL assert exactly one of inst_ok/data_ok, for the requester served, then return to IDLE unconditionally.
REQ-014 The block SHALL make no grant in RESP; the served requester's req, still high that cycle, SHALL be ignored.
REQ-015 Latency: with a request seen in IDLE at cycle 0 and mem_ok at cycle 1+w (w≥0), the block SHALL:
- raise mem_req at cycle 1;
- pulse ok at cycle 2+w;
- accept the next grant decision at cycle 3+w.
REQ-016 A wait counter SHALL clear on every grant and increment each cycle in INST/DATA while mem_ok=0.
REQ-017 When the wait counter reaches TIMEOUT, err_timeout SHALL set and stay set until reset.
REQ-018 A timeout SHALL NOT abort the access; the FSM continues waiting for mem_ok.
REQ-019 The wait counter SHALL saturate at TIMEOUT and not wrap.
REQ-020 mem_ok in IDLE or RESP SHALL be ignored and SHALL NOT change state or data.
REQ-021 A requester dropping its req while granted is illegal; the arbiter SHALL still complete the access and pulse ok.
REQ-022 stall SHALL be 0 whenever no request is pending.

Reset
REQ-023 On rst=1, asynchronously and without waiting for a clock edge, the block SHALL:
- enter state IDLE;
- drive mem_req, inst_ok, data_ok and err_timeout to 0;
- clear mem_wen, mem_addr, mem_wdata, inst_rdata and data_rdata to 0;
- set last_grant to INST, so data wins the first conflict;
- clear the wait counter to 0.
REQ-024 A reset asserted mid-access SHALL abandon the access, and no ok SHALL follow after release.
REQ-025 After reset release, the first grant SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-026 The bench SHALL cover the following directed scenarios.
- Single fetch: inst_req, addr=0xBFC00000, mem_ok at cycle 3 with rdata=0x24020001 -> mem_req at cycle 1, inst_ok=1 at cycle 4, inst_rdata=0x24020001, stall=1 at cycles 0-3.
- Conflict: inst_req and data_req (load 0x80000010) both high from reset -> data granted first, data_ok then inst_ok; next conflict -> inst first.
- Store: data_wen=0011, wdata=0xAABBCCDD, addr=0x10 -> mem_wen=0011, mem_wdata=0xAABBCCDD, data_ok pulses, data_rdata unchanged.
- Back-to-back fetches with mem_ok=1 immediately -> one ok every 3 cycles, never two oks in one cycle.
- Timeout: TIMEOUT=4, mem_ok withheld 10 cycles -> err_timeout=1 from the 5th wait cycle, ok still pulses after mem_ok, flag persists.
- Reset mid-access: rst pulsed while state DATA -> mem_req=0 immediately, no data_ok afterwards, all outputs 0.
